// File: rtl/icache_l1_refill.sv
// Refill engine behind the L1 instruction cache replacement port: fetches a whole
// block from backing memory one 64-bit beat at a time, then streams it to the cache.
module icache_l1_refill #(
   parameter int B = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        L1IMiss,
   input  logic [31:0] Address,
   output logic        RepReady,
   output logic [63:0] RepWord,
   output logic        RefillBusy,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemAck,
   input  logic        MemRdValid,
   input  logic [63:0] MemRdData
);

   localparam int BEATS = B / 8;
   localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, DONE} RefillState;

   RefillState      state, stateNext;
   logic [CNTW-1:0] beatCnt, beatCntNext;
   logic [31:0]     blockAddr, blockAddrNext;
   logic            beatHeld, beatHeldNext;
   logic            bufWrite;
   logic [63:0]     repWordNext;
   logic [63:0]     lineBuf [BEATS];

   // Next-state logic; a beat returned together with its ack is captured in REQ
   // and marked held so WAIT advances without needing a second valid.
   always_comb begin
      stateNext     = state;
      beatCntNext   = beatCnt;
      blockAddrNext = blockAddr;
      beatHeldNext  = beatHeld;
      bufWrite      = 1'b0;
      case (state)
         IDLE: begin
            if (L1IMiss) begin
               stateNext     = REQ;
               blockAddrNext = Address & ~(32'(B) - 32'd1);
               beatCntNext   = '0;
               beatHeldNext  = 1'b0;
            end
         end
         REQ: begin
            if (MemAck) begin
               stateNext = WAIT;
               if (MemRdValid) begin
                  bufWrite     = 1'b1;
                  beatHeldNext = 1'b1;
               end
            end
         end
         WAIT: begin
            if (MemRdValid || beatHeld) begin
               bufWrite     = !beatHeld;
               beatHeldNext = 1'b0;
               if (beatCnt == LAST) begin
                  beatCntNext = '0;
                  stateNext   = STREAM;
               end else begin
                  beatCntNext = beatCnt + CNTW'(1);
                  stateNext   = REQ;
               end
            end
         end
         STREAM: begin
            if (beatCnt == LAST) begin
               beatCntNext = '0;
               stateNext   = DONE;
            end else begin
               beatCntNext = beatCnt + CNTW'(1);
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      repWordNext = (bufWrite && (beatCnt == beatCntNext)) ? MemRdData : lineBuf[beatCntNext];
   end

   // State and registered outputs, all derived from the next state so they
   // line up with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         beatCnt    <= '0;
         blockAddr  <= '0;
         beatHeld   <= 1'b0;
         RepReady   <= 1'b0;
         RepWord    <= '0;
         RefillBusy <= 1'b0;
         MemReq     <= 1'b0;
         MemAddr    <= '0;
      end else begin
         state      <= stateNext;
         beatCnt    <= beatCntNext;
         blockAddr  <= blockAddrNext;
         beatHeld   <= beatHeldNext;
         RepReady   <= (stateNext == STREAM);
         RepWord    <= (stateNext == STREAM) ? repWordNext : '0;
         RefillBusy <= (stateNext != IDLE);
         MemReq     <= (stateNext == REQ);
         if (stateNext == REQ) begin
            MemAddr <= blockAddrNext | (32'(beatCntNext) << 3);
         end
      end
   end

   // Line buffer has no reset; its contents only matter once fully written.
   always_ff @(posedge clk) begin
      if (bufWrite) begin
         lineBuf[beatCnt] <= MemRdData;
      end
   end

endmodule

// File: tb/tb_icache_l1_refill.sv
// Directed bench for icache_l1_refill: a small backing-memory responder plus
// hand-computed address and data sequences for each refill scenario.
module tb_icache_l1_refill;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        L1IMiss = 1'b0;
   logic [31:0] Address = '0;
   logic        RepReady;
   logic [63:0] RepWord;
   logic        RefillBusy;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemAck;
   logic        MemRdValid;
   logic [63:0] MemRdData;

   logic        tieHigh = 1'b0;
   logic        ackReg = 1'b0;
   logic        validReg = 1'b0;
   logic [63:0] dataReg = '0;
   logic        memBusy = 1'b0;
   int          memWait = 0;
   logic [31:0] memAddrHeld = '0;

   logic [31:0] reqLog[$];
   logic [63:0] streamLog[$];
   int          repCyc[$];
   int          cyc = 0;

   int compared = 0;
   int mismatched = 0;

   icache_l1_refill #(.B(64)) dut (
      .clk(clk), .reset(reset), .L1IMiss(L1IMiss), .Address(Address),
      .RepReady(RepReady), .RepWord(RepWord), .RefillBusy(RefillBusy),
      .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
      .MemRdValid(MemRdValid), .MemRdData(MemRdData)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] memData(input logic [31:0] a);
      return {a ^ 32'hDEAD_0000, a};
   endfunction

   assign MemAck     = tieHigh | ackReg;
   assign MemRdValid = tieHigh | validReg;
   assign MemRdData  = tieHigh ? memData(MemAddr) : dataReg;

   // Backing memory: ack a request, return its data two cycles after the ack.
   always @(negedge clk) begin
      ackReg   = 1'b0;
      validReg = 1'b0;
      if (!reset) begin
         memBusy = 1'b0;
      end else if (tieHigh) begin
         if (MemReq) reqLog.push_back(MemAddr);
      end else if (memBusy) begin
         if (memWait == 0) begin
            validReg = 1'b1;
            dataReg  = memData(memAddrHeld);
            memBusy  = 1'b0;
         end else begin
            memWait--;
         end
      end else if (MemReq) begin
         ackReg      = 1'b1;
         memBusy     = 1'b1;
         memWait     = 1;
         memAddrHeld = MemAddr;
         reqLog.push_back(MemAddr);
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (RepReady) begin
         streamLog.push_back(RepWord);
         repCyc.push_back(cyc);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic miss, input logic [31:0] addr);
      L1IMiss = miss;
      Address = addr;
   endtask

   task automatic clearLogs();
      reqLog.delete();
      streamLog.delete();
      repCyc.delete();
   endtask

   // Wait for RepReady to fall (returns in the DONE cycle); counts idle cycles seen.
   task automatic waitRepFall(input string tag, output int idleSeen);
      logic prev;
      logic seen;
      prev = RepReady;
      seen = 1'b0;
      idleSeen = 0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         if (!RefillBusy) idleSeen++;
         if (prev && !RepReady) seen = 1'b1;
         prev = RepReady;
      end
      checkOutput({tag, "_streamEnd"}, 64'(seen), 64'd1);
   endtask

   task automatic checkBlock(input string tag, input int first, input logic [31:0] base);
      if (reqLog.size() >= first + 8 && streamLog.size() >= first + 8) begin
         for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_addr%0d", tag, k), 64'(reqLog[first+k]), 64'(base + 32'(8*k)));
            checkOutput($sformatf("%s_word%0d", tag, k), streamLog[first+k], memData(base + 32'(8*k)));
         end
         checkOutput({tag, "_consecutive"}, 64'(repCyc[first+7] - repCyc[first]), 64'd7);
      end else begin
         checkOutput({tag, "_logSize"}, 64'(streamLog.size()), 64'(first + 8));
      end
   endtask

   initial begin
      int idleSeen;
      int firstRep;
      int highCnt;
      logic anyBad;

      // Reset and idle
      applyStimulus(1'b0, 32'h0);
      repeat (5) @(negedge clk);
      checkOutput("rst_RepReady", 64'(RepReady), 64'd0);
      checkOutput("rst_RepWord", RepWord, 64'd0);
      checkOutput("rst_MemReq", 64'(MemReq), 64'd0);
      checkOutput("rst_MemAddr", 64'(MemAddr), 64'd0);
      checkOutput("rst_RefillBusy", 64'(RefillBusy), 64'd0);
      reset = 1'b1;
      anyBad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (RepReady || MemReq || RefillBusy) anyBad = 1'b1;
      end
      checkOutput("idle_quiet", 64'(anyBad), 64'd0);

      // Basic refill with 2-cycle memory latency
      clearLogs();
      applyStimulus(1'b1, 32'h0000_1234);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0000_1234);
      waitRepFall("t2", idleSeen);
      repeat (3) @(negedge clk);
      checkOutput("t2_nreq", 64'(reqLog.size()), 64'd8);
      checkOutput("t2_nbeat", 64'(streamLog.size()), 64'd8);
      checkBlock("t2", 0, 32'h0000_1200);

      // Zero-latency memory: first RepReady on the 17th edge counting the miss edge
      clearLogs();
      tieHigh = 1'b1;
      applyStimulus(1'b1, 32'h0000_0A10);
      firstRep = 0;
      highCnt = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         L1IMiss = 1'b0;
         if (RepReady) begin
            if (firstRep == 0) firstRep = n;
            highCnt++;
         end
      end
      tieHigh = 1'b0;
      checkOutput("t3_latency", 64'(firstRep), 64'd17);
      checkOutput("t3_highCycles", 64'(highCnt), 64'd8);
      checkOutput("t3_lowAfter", 64'(RepReady), 64'd0);
      checkBlock("t3", 0, 32'h0000_0A00);

      // Address/miss changes during the refill are ignored, also during DONE
      clearLogs();
      applyStimulus(1'b1, 32'h0000_1234);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0000_1234);
      @(negedge clk);
      begin
         logic prev;
         logic ended;
         prev = RepReady;
         ended = 1'b0;
         for (int i = 0; i < 600 && !ended; i++) begin
            @(negedge clk);
            if (prev && !RepReady) ended = 1'b1;
            else applyStimulus(~L1IMiss, 32'hFFFF_FFC4);
            prev = RepReady;
         end
         checkOutput("t4_streamEnd", 64'(ended), 64'd1);
      end
      applyStimulus(1'b1, 32'hFFFF_FFC4);
      @(negedge clk);
      checkOutput("t4_doneIgnoresMiss", 64'(RefillBusy), 64'd0);
      applyStimulus(1'b0, 32'h0);
      repeat (4) @(negedge clk);
      checkOutput("t4_noSecondRefill", 64'(RefillBusy), 64'd0);
      checkOutput("t4_nreq", 64'(reqLog.size()), 64'd8);
      checkBlock("t4", 0, 32'h0000_1200);

      // Reset during stream beat 3 aborts at once
      clearLogs();
      applyStimulus(1'b1, 32'h0000_1234);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0);
      highCnt = 0;
      for (int i = 0; i < 600 && highCnt < 4; i++) begin
         @(negedge clk);
         if (RepReady) highCnt++;
      end
      checkOutput("t5_reachedBeat3", 64'(highCnt), 64'd4);
      #1 reset = 1'b0;
      #1;
      checkOutput("t5_abortRepReady", 64'(RepReady), 64'd0);
      checkOutput("t5_abortMemReq", 64'(MemReq), 64'd0);
      checkOutput("t5_abortBusy", 64'(RefillBusy), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      clearLogs();
      repeat (5) @(negedge clk);
      checkOutput("t5_noResume", 64'(streamLog.size()), 64'd0);
      applyStimulus(1'b1, 32'h0000_0040);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0);
      waitRepFall("t5", idleSeen);
      repeat (3) @(negedge clk);
      checkBlock("t5", 0, 32'h0000_0040);

      // Back-to-back misses with L1IMiss held high through DONE
      clearLogs();
      applyStimulus(1'b1, 32'h0000_1234);
      waitRepFall("t6a", idleSeen);
      Address = 32'h0000_2008;
      waitRepFall("t6b", idleSeen);
      checkOutput("t6_idleGap", 64'(idleSeen), 64'd1);
      applyStimulus(1'b0, 32'h0);
      repeat (4) @(negedge clk);
      checkOutput("t6_totalBeats", 64'(streamLog.size()), 64'd16);
      checkOutput("t6_nreq", 64'(reqLog.size()), 64'd16);
      checkBlock("t6a", 0, 32'h0000_1200);
      checkBlock("t6b", 8, 32'h0000_2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
